// File: rtl/twenty_bit_serial_subtractor.sv
// Digit-serial subtractor: d = a - b over WIDTH bits, DIGIT bits per clock, LSB first.
// Optional zero/ovf flag outputs are enabled by defining SUB_FLAGS_EN.
module twenty_bit_serial_subtractor #(
    parameter int WIDTH = 20,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_borrow;
    logic [SW-1:0]    r_step;
    logic             r_ready;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             w_accept;
    logic             w_last;
    logic             w_finish;
    logic [DIGIT:0]   w_slice;
    logic [WIDTH-1:0] w_acc_nxt;

`ifdef SUB_FLAGS_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_zero;
    logic             r_ovf;

    // Signed overflow of a - b from the operand sign bits and the result sign bit.
    function automatic logic f_sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction
`endif

    // Only a DIGIT-wide borrow chain: the extra MSB of the slice is the borrow out.
    assign w_slice   = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};
    assign w_acc_nxt = {w_slice[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_step == SW'(NSTEP - 1));
    assign w_finish  = (r_state == S_RUN) && w_last;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one RUN pass of NSTEP steps per accepted start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand shift registers, borrow, step counter and result accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_step   <= {SW{1'b0}};
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= {WIDTH{1'b0}};
            r_borrow <= 1'b0;
            r_step   <= {SW{1'b0}};
        end else if (r_state == S_RUN) begin
            r_a      <= {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            r_b      <= {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
            r_acc    <= w_acc_nxt;
            r_borrow <= w_slice[DIGIT];
            r_step   <= r_step + SW'(1);
        end else begin
            r_a      <= r_a;
            r_b      <= r_b;
            r_acc    <= r_acc;
            r_borrow <= r_borrow;
            r_step   <= r_step;
        end
    end

    // Handshake outputs; ready tracks the state the FSM is about to enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= w_finish;
        end
    end

    // Result registers change only when the last step completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d    <= {WIDTH{1'b0}};
            r_bout <= 1'b0;
        end else if (w_finish) begin
            r_d    <= w_acc_nxt;
            r_bout <= w_slice[DIGIT];
        end else begin
            r_d    <= r_d;
            r_bout <= r_bout;
        end
    end

`ifdef SUB_FLAGS_EN
    // Operand signs are kept because the shift registers lose them during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_zero  <= r_zero;
            r_ovf   <= r_ovf;
        end else if (w_finish) begin
            r_a_msb <= r_a_msb;
            r_b_msb <= r_b_msb;
            r_zero  <= (w_acc_nxt == {WIDTH{1'b0}});
            r_ovf   <= f_sub_ovf(r_a_msb, r_b_msb, w_acc_nxt[WIDTH-1]);
        end else begin
            r_a_msb <= r_a_msb;
            r_b_msb <= r_b_msb;
            r_zero  <= r_zero;
            r_ovf   <= r_ovf;
        end
    end

    assign zero = r_zero;
    assign ovf  = r_ovf;
`endif

    assign ready = r_ready;
    assign done  = r_done;
    assign d     = r_d;
    assign bout  = r_bout;

endmodule

// File: tb/tb_twenty_bit_serial_subtractor.sv
// Directed bench for twenty_bit_serial_subtractor; flag checks compile in with SUB_FLAGS_EN.
module tb_twenty_bit_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] a;
    logic [19:0] b;
    logic        ready;
    logic        done;
    logic [19:0] d;
    logic        bout;
`ifdef SUB_FLAGS_EN
    logic        zero;
    logic        ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    twenty_bit_serial_subtractor #(.WIDTH(20), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SUB_FLAGS_EN
        ,
        .zero  (zero),
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one accepting edge; returns 1 time unit after that edge.
    task automatic issue(input logic [19:0] ta, input logic [19:0] tb_v);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges until done is seen (0 if it never arrives within the budget).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [19:0] ta, input logic [19:0] tb_v,
                         input logic [19:0] exp_d, input logic exp_b);
        int c;
        issue(ta, tb_v);
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        a = 20'h12345;
        b = 20'h54321;
        wait_done(c);
        chk({tag, "_lat"}, 32'(c), 32'd5);
        chk({tag, "_d"}, 32'(d), 32'(exp_d));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_b));
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int c;
        int ndone;
        logic [19:0] dval;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 20'd0;
        b     = 20'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_FLAGS_EN
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        do_op("s1000m1", 20'd1000, 20'd1, 20'd999, 1'b0);
        do_op("s0m1", 20'd0, 20'd1, 20'hFFFFF, 1'b1);
        do_op("s222m111", 20'd222, 20'd111, 20'd111, 1'b0);
        do_op("sAm5", 20'hAAAAA, 20'h55555, 20'h55555, 1'b0);

`ifdef SUB_FLAGS_EN
        do_op("fz", 20'hFFFFF, 20'hFFFFF, 20'd0, 1'b0);
        chk("fz_zero", 32'(zero), 32'd1);
        chk("fz_ovf", 32'(ovf), 32'd0);
        do_op("fo", 20'h7FFFF, 20'hFFFFF, 20'h80000, 1'b1);
        chk("fo_zero", 32'(zero), 32'd0);
        chk("fo_ovf", 32'(ovf), 32'd1);
`endif

        // Second start during RUN must not disturb the op in flight.
        issue(20'd5, 20'd3);
        @(negedge clk);
        a     = 20'd9;
        b     = 20'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        dval  = 20'd0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                dval = d;
            end
        end
        chk("busy_ndone", 32'(ndone), 32'd1);
        chk("busy_d", 32'(dval), 32'd2);

        // Start held high: the done cycle accepts the next op.
        @(negedge clk);
        a     = 20'd10;
        b     = 20'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 20'd4;
        b = 20'd10;
        chk("b2b_mid_d", 32'(d), 32'd2);
        wait_done(c);
        chk("b2b1_lat", 32'(c), 32'd5);
        chk("b2b1_d", 32'(d), 32'd6);
        chk("b2b1_bout", 32'(bout), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_drop", 32'(done), 32'd0);
        chk("b2b_acc", 32'(ready), 32'd0);
        chk("b2b_hold", 32'(d), 32'd6);
        wait_done(c);
        start = 1'b0;
        chk("b2b2_lat", 32'(c), 32'd5);
        chk("b2b2_d", 32'(d), 32'hFFFFA);
        chk("b2b2_bout", 32'(bout), 32'd1);

        // Reset in the middle of RUN aborts the op with no done.
        issue(20'd1000, 20'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
            end
        end
        chk("abort_nodone", 32'(ndone), 32'd0);

        do_op("post", 20'd4, 20'd10, 20'hFFFFA, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
